sram_ctrl: RTL and testbench
============================

SRAM_CTRL -- requirements
Module: sram_ctrl

Interface
REQ-001 SHALL have parameter ADR, default 8, address width in bits.
REQ-002 SHALL have parameter Data, default 8, data width in bits.
REQ-003 SHALL use one clock and an asynchronous, active-high reset: CLK input 1, rising-edge clock; RST input 1, asynchronous active-high reset.
REQ-004 ReqValid  input  1  host burst request valid.
REQ-005 ReqReady  output  1  controller accepts a request; high only in IDLE.
REQ-006 ReqWrite  input  1  1 = write burst, 0 = read burst.
REQ-007 ReqAddr  input  ADR  burst start address.
REQ-008 ReqLen  input  ADR  beats minus one (0 = 1 beat, 2^ADR-1 = 2^ADR beats).
REQ-009 WrValid  input  1  write beat data valid.
REQ-010 WrReady  output  1  write beat accepted; high only in WRITE.
REQ-011 WrData  input  Data  write beat data.
REQ-012 RdValid  output  1  read beat data valid, one-cycle pulse per beat, no backpressure.
REQ-013 RdData  output  Data  read beat data.
REQ-014 RdLast  output  1  high with RdValid on the final beat of a read burst.
REQ-015 Busy  output  1  high in any state other than IDLE.
REQ-016 MemCS, MemWE, MemRD  output  1 each  SRAM chip select, write enable, read enable.
REQ-017 MemAddr  output  ADR  SRAM address; MemDataIn  output  Data  SRAM write data; MemDataOut  input  Data  SRAM read data, registered by the SRAM on the same edge it samples MemRD=1.

Function
REQ-018 SHALL implement the states IDLE, WRITE, READ and DRAIN.
REQ-019 In IDLE, ReqValid=1 at a rising edge SHALL latch ReqAddr into the address counter, ReqLen into the beat counter and ReqWrite into the direction, then enter WRITE (ReqWrite=1) or READ (ReqWrite=0).
REQ-020 ReqValid while Busy=1 SHALL be ignored; the host SHALL hold the request until ReqReady=1.
REQ-021 In WRITE, WrReady=1; on each cycle with WrValid=1: MemCS=1, MemWE=1, MemRD=0, MemAddr=counter, MemDataIn=WrData.
REQ-022 In WRITE, a cycle with WrValid=0 SHALL drive MemCS=MemWE=0 and SHALL NOT advance the counters.
REQ-023 In READ, every cycle SHALL drive MemCS=1, MemRD=1, MemWE=0, MemAddr=counter.
REQ-024 Each issued beat SHALL increment the address modulo 2^ADR (2^ADR-1 wraps to 0) and decrement the beat counter.
REQ-025 The final write beat (beat counter=0) SHALL return the FSM to IDLE; the final read beat SHALL move it to DRAIN.
REQ-026 DRAIN SHALL last exactly one cycle with all Mem strobes low, then return to IDLE.
REQ-027 A read strobe sampled at edge E SHALL produce RdData=MemDataOut and RdValid=1 registered at edge E+1, for a latency of 2 cycles from the strobe cycle.
REQ-028 A read burst of N beats SHALL produce N consecutive RdValid pulses, with RdLast on pulse N occurring in the first IDLE cycle after DRAIN.
REQ-029 MemWE and MemRD SHALL never be high in the same cycle, and outside WRITE and READ all Mem strobes SHALL be 0.
REQ-030 A new request SHALL be accepted in the same IDLE cycle that shows the last RdValid, and the next burst's beats SHALL follow without a gap.

Reset
REQ-031 RST=1 SHALL immediately, without waiting for a clock edge, force state IDLE, counters 0, and ReqReady=0, WrReady=0, RdValid=0, RdLast=0, Busy=0, MemCS=MemWE=MemRD=0, MemAddr=0, MemDataIn=0, RdData=0.
REQ-032 ReqReady SHALL rise in the first cycle after RST deasserts.
REQ-033 Reset mid-burst SHALL abandon the burst, SHALL suppress any pending RdValid and SHALL issue no further SRAM strobes.

Verification
REQ-034 Write burst ReqAddr=0x10, ReqLen=3, WrData 0xA0..0xA3 with WrValid continuous -> four MemWE pulses at addresses 0x10..0x13, then IDLE.
REQ-035 Read back ReqAddr=0x10, ReqLen=3 -> RdValid on 4 consecutive cycles with RdData 0xA0,0xA1,0xA2,0xA3 and RdLast on 0xA3, the first beat 2 cycles after the first MemRD.
REQ-036 Wrap: write ReqAddr=0xFE, ReqLen=2 -> MemAddr 0xFE, 0xFF, 0x00.
REQ-037 Write burst with WrValid low for 2 cycles mid-burst -> no MemCS in those cycles, addresses contiguous, 4 beats total.
REQ-038 RST asserted during the 2nd beat of a 4-beat read -> all outputs 0 in the same cycle, no RdValid afterwards, ReqReady=1 one cycle after RST falls.
REQ-039 ReqLen=0xFF read from 0x00 -> 256 RdValid pulses, RdLast only on the beat for address 0xFF.

Source files
------------

// File: rtl/sram_ctrl_if.sv
// Host burst and SRAM pin bundle for sram_ctrl.
interface sram_ctrl_if #(
  parameter int ADR  = 8,
  parameter int Data = 8
);
  logic            ReqValid;
  logic            ReqReady;
  logic            ReqWrite;
  logic [ADR-1:0]  ReqAddr;
  logic [ADR-1:0]  ReqLen;
  logic            WrValid;
  logic            WrReady;
  logic [Data-1:0] WrData;
  logic            RdValid;
  logic [Data-1:0] RdData;
  logic            RdLast;
  logic            Busy;
  logic            MemCS;
  logic            MemWE;
  logic            MemRD;
  logic [ADR-1:0]  MemAddr;
  logic [Data-1:0] MemDataIn;
  logic [Data-1:0] MemDataOut;

  modport slave (
    input  ReqValid, ReqWrite, ReqAddr, ReqLen, WrValid, WrData, MemDataOut,
    output ReqReady, WrReady, RdValid, RdData, RdLast, Busy,
           MemCS, MemWE, MemRD, MemAddr, MemDataIn
  );

  modport master (
    output ReqValid, ReqWrite, ReqAddr, ReqLen, WrValid, WrData, MemDataOut,
    input  ReqReady, WrReady, RdValid, RdData, RdLast, Busy,
           MemCS, MemWE, MemRD, MemAddr, MemDataIn
  );
endinterface

// File: rtl/sram_ctrl.sv
// Burst controller for a synchronous single-port SRAM.
//
// state | meaning
// IDLE  | waiting for a host request, ReqReady high
// WRITE | one SRAM write per cycle with WrValid high
// READ  | one SRAM read strobe every cycle
// DRAIN | one quiet cycle while the last read beat is returned
module sram_ctrl #(
  parameter int ADR  = 8,
  parameter int Data = 8
) (
  input logic        CLK,
  input logic        RST,
  sram_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, WRITE, READ, DRAIN} state_t;

  state_t          state_q, state_d;
  logic [ADR-1:0]  addr_q;
  logic [ADR-1:0]  beat_q;
  logic            wr_beat, rd_beat;
  logic            rd_pend_q, rd_last_pend_q;
  logic            rd_valid_q, rd_last_q;
  logic [Data-1:0] rd_data_q;

  // State register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state and SRAM strobes from the current state.
  always_comb begin
    state_d = state_q;
    wr_beat = 1'b0;
    rd_beat = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.ReqValid) state_d = bus.ReqWrite ? WRITE : READ;
      end
      WRITE: begin
        wr_beat = bus.WrValid;
        if (bus.WrValid && (beat_q == '0)) state_d = IDLE;
      end
      READ: begin
        rd_beat = 1'b1;
        if (beat_q == '0) state_d = DRAIN;
      end
      DRAIN: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Address and beat counters: loaded on accept, stepped on every issued beat.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      addr_q <= '0;
      beat_q <= '0;
    end else if ((state_q == IDLE) && bus.ReqValid) begin
      addr_q <= bus.ReqAddr;
      beat_q <= bus.ReqLen;
    end else if (wr_beat || rd_beat) begin
      addr_q <= addr_q + 1'b1;
      beat_q <= beat_q - 1'b1;
    end
  end

  // Read return pipe: the SRAM registers data on the strobe edge, we register it one edge later.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rd_pend_q      <= 1'b0;
      rd_last_pend_q <= 1'b0;
      rd_valid_q     <= 1'b0;
      rd_last_q      <= 1'b0;
      rd_data_q      <= '0;
    end else begin
      rd_pend_q      <= rd_beat;
      rd_last_pend_q <= rd_beat && (beat_q == '0);
      rd_valid_q     <= rd_pend_q;
      rd_last_q      <= rd_last_pend_q;
      rd_data_q      <= rd_pend_q ? bus.MemDataOut : '0;
    end
  end

  // ReqReady is gated by RST so it drops the moment reset asserts.
  assign bus.ReqReady  = (state_q == IDLE) && !RST;
  assign bus.WrReady   = (state_q == WRITE);
  assign bus.Busy      = (state_q != IDLE);
  assign bus.MemCS     = wr_beat || rd_beat;
  assign bus.MemWE     = wr_beat;
  assign bus.MemRD     = rd_beat;
  assign bus.MemAddr   = addr_q;
  assign bus.MemDataIn = wr_beat ? bus.WrData : '0;
  assign bus.RdValid   = rd_valid_q;
  assign bus.RdLast    = rd_last_q;
  assign bus.RdData    = rd_data_q;

endmodule

// File: tb/tb_sram_ctrl.sv
// Directed bench for sram_ctrl with a behavioural synchronous SRAM.
module tb_sram_ctrl;

  localparam logic H = 1'b1;
  localparam logic L = 1'b0;

  typedef struct packed {
    logic       rr, wr, bsy, cs, we, rd;
    logic [7:0] ma, md;
    logic       vld;
    logic [7:0] rdd;
    logic       last;
  } out_t;

  typedef struct packed {
    logic       rv, rw;
    logic [7:0] ra, rl;
    logic       wv;
    logic [7:0] wd;
    out_t       e;
  } vec_t;

  logic CLK;
  logic RST;
  int   vecs = 0;
  int   fails = 0;
  int   overlap = 0;

  sram_ctrl_if #(.ADR(8), .Data(8)) bus ();

  sram_ctrl #(.ADR(8), .Data(8)) dut (.CLK(CLK), .RST(RST), .bus(bus));

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Behavioural SRAM: unwritten locations read back a fixed pattern.
  logic [7:0] sram [256];
  bit         written [256];

  function automatic logic [7:0] pat(int i);
    logic [7:0] b;
    b = 8'(i);
    return b ^ 8'h5A;
  endfunction

  always @(posedge CLK) begin
    if (bus.MemCS && bus.MemWE) begin
      sram[bus.MemAddr]    <= bus.MemDataIn;
      written[bus.MemAddr] <= 1'b1;
    end
    if (bus.MemCS && bus.MemRD)
      bus.MemDataOut <= written[bus.MemAddr] ? sram[bus.MemAddr] : pat(int'(bus.MemAddr));
  end

  always @(negedge CLK) begin
    #2;
    if (bus.MemWE && bus.MemRD) overlap++;
  end

  function automatic out_t outs();
    out_t o;
    o = {bus.ReqReady, bus.WrReady, bus.Busy, bus.MemCS, bus.MemWE, bus.MemRD,
         bus.MemAddr, bus.MemDataIn, bus.RdValid, bus.RdData, bus.RdLast};
    return o;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_int(input string nm, input int act, input int exp);
    vecs++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    bus.ReqValid = v.rv;
    bus.ReqWrite = v.rw;
    bus.ReqAddr  = v.ra;
    bus.ReqLen   = v.rl;
    bus.WrValid  = v.wv;
    bus.WrData   = v.wd;
  endtask

  vec_t       tbl [24];
  logic [7:0] exp_mem [256];

  initial begin
    int n, first, bad;
    logic [7:0] b;

    for (int i = 0; i < 256; i++) exp_mem[i] = pat(i);
    exp_mem[8'h10] = 8'hA0; exp_mem[8'h11] = 8'hA1;
    exp_mem[8'h12] = 8'hA2; exp_mem[8'h13] = 8'hA3;
    exp_mem[8'hFE] = 8'h11; exp_mem[8'hFF] = 8'h22;
    exp_mem[8'h00] = 8'h33; exp_mem[8'h01] = 8'h44;

    //            rv rw ra     rl     wv wd        rr wr bsy cs we rd ma     md     vld rdd    last
    // write 0x10..0x13
    tbl[0]  = {H, H, 8'h10, 8'h03, L, 8'h00,    H, L, L, L, L, L, 8'h00, 8'h00, L, 8'h00, L};
    tbl[1]  = {L, L, 8'h00, 8'h00, H, 8'hA0,    L, H, H, H, H, L, 8'h10, 8'hA0, L, 8'h00, L};
    tbl[2]  = {L, L, 8'h00, 8'h00, H, 8'hA1,    L, H, H, H, H, L, 8'h11, 8'hA1, L, 8'h00, L};
    tbl[3]  = {L, L, 8'h00, 8'h00, H, 8'hA2,    L, H, H, H, H, L, 8'h12, 8'hA2, L, 8'h00, L};
    tbl[4]  = {L, L, 8'h00, 8'h00, H, 8'hA3,    L, H, H, H, H, L, 8'h13, 8'hA3, L, 8'h00, L};
    // read back 0x10..0x13
    tbl[5]  = {H, L, 8'h10, 8'h03, L, 8'h00,    H, L, L, L, L, L, 8'h14, 8'h00, L, 8'h00, L};
    tbl[6]  = {L, L, 8'h00, 8'h00, L, 8'h00,    L, L, H, H, L, H, 8'h10, 8'h00, L, 8'h00, L};
    tbl[7]  = {L, L, 8'h00, 8'h00, L, 8'h00,    L, L, H, H, L, H, 8'h11, 8'h00, L, 8'h00, L};
    tbl[8]  = {L, L, 8'h00, 8'h00, L, 8'h00,    L, L, H, H, L, H, 8'h12, 8'h00, H, 8'hA0, L};
    tbl[9]  = {L, L, 8'h00, 8'h00, L, 8'h00,    L, L, H, H, L, H, 8'h13, 8'h00, H, 8'hA1, L};
    tbl[10] = {L, L, 8'h00, 8'h00, L, 8'h00,    L, L, H, L, L, L, 8'h14, 8'h00, H, 8'hA2, L};
    // accept wrapping write in the same cycle as the last read beat
    tbl[11] = {H, H, 8'hFE, 8'h03, L, 8'h00,    H, L, L, L, L, L, 8'h14, 8'h00, H, 8'hA3, H};
    tbl[12] = {L, L, 8'h00, 8'h00, H, 8'h11,    L, H, H, H, H, L, 8'hFE, 8'h11, L, 8'h00, L};
    tbl[13] = {H, L, 8'h00, 8'h00, L, 8'h00,    L, H, H, L, L, L, 8'hFF, 8'h00, L, 8'h00, L};
    tbl[14] = {H, L, 8'h00, 8'h00, L, 8'h00,    L, H, H, L, L, L, 8'hFF, 8'h00, L, 8'h00, L};
    tbl[15] = {L, L, 8'h00, 8'h00, H, 8'h22,    L, H, H, H, H, L, 8'hFF, 8'h22, L, 8'h00, L};
    tbl[16] = {L, L, 8'h00, 8'h00, H, 8'h33,    L, H, H, H, H, L, 8'h00, 8'h33, L, 8'h00, L};
    tbl[17] = {L, L, 8'h00, 8'h00, H, 8'h44,    L, H, H, H, H, L, 8'h01, 8'h44, L, 8'h00, L};
    // read across the wrap
    tbl[18] = {H, L, 8'hFF, 8'h01, L, 8'h00,    H, L, L, L, L, L, 8'h02, 8'h00, L, 8'h00, L};
    tbl[19] = {L, L, 8'h00, 8'h00, L, 8'h00,    L, L, H, H, L, H, 8'hFF, 8'h00, L, 8'h00, L};
    tbl[20] = {L, L, 8'h00, 8'h00, H, 8'h77,    L, L, H, H, L, H, 8'h00, 8'h00, L, 8'h00, L};
    tbl[21] = {L, L, 8'h00, 8'h00, L, 8'h00,    L, L, H, L, L, L, 8'h01, 8'h00, H, 8'h22, L};
    tbl[22] = {L, L, 8'h00, 8'h00, L, 8'h00,    H, L, L, L, L, L, 8'h01, 8'h00, H, 8'h33, H};
    tbl[23] = {L, L, 8'h00, 8'h00, L, 8'h00,    H, L, L, L, L, L, 8'h01, 8'h00, L, 8'h00, L};

    // reset held with a request pending: everything low, ReqReady included
    RST = 1'b1;
    drive({H, H, 8'h10, 8'h03, H, 8'h55, 32'h0});
    @(negedge CLK); #1;
    chk("reset_outputs", outs(), 32'h0);
    @(negedge CLK);
    drive({L, L, 8'h00, 8'h00, L, 8'h00, 32'h0});
    RST = 1'b0;
    #1;
    chk("ready_after_reset", outs(), {H, L, L, L, L, L, 8'h00, 8'h00, L, 8'h00, L});

    for (int i = 0; i < 24; i++) begin
      @(negedge CLK);
      drive(tbl[i]);
      #1;
      chk($sformatf("vec%0d", i), outs(), tbl[i].e);
    end

    // reset during the second beat of a 4-beat read
    @(negedge CLK);
    drive({H, L, 8'h10, 8'h03, L, 8'h00, 32'h0});
    @(negedge CLK);
    drive({L, L, 8'h00, 8'h00, L, 8'h00, 32'h0});
    @(negedge CLK); #1;
    chk("rst_seq_beat2", outs(), {L, L, H, H, L, H, 8'h11, 8'h00, L, 8'h00, L});
    #2 RST = 1'b1;
    #1;
    chk("rst_async_clear", outs(), 32'h0);
    @(negedge CLK);
    RST = 1'b0;
    #1;
    chk("rst_release_ready", outs(), {H, L, L, L, L, L, 8'h00, 8'h00, L, 8'h00, L});
    bad = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge CLK); #1;
      if (bus.RdValid || bus.MemCS || !bus.ReqReady) bad++;
    end
    chk_int("rst_no_activity", bad, 0);

    // full-range read: 256 beats from 0x00
    @(negedge CLK);
    drive({H, L, 8'h00, 8'hFF, L, 8'h00, 32'h0});
    @(negedge CLK);
    drive({L, L, 8'h00, 8'h00, L, 8'h00, 32'h0});
    n = 0;
    first = -1;
    for (int cyc = 1; cyc <= 300 && n < 256; cyc++) begin
      if (cyc > 1) @(negedge CLK);
      #1;
      if (bus.RdValid) begin
        if (first < 0) begin
          first = cyc;
          chk_int("long_first_latency", cyc, 3);
        end
        chk_int($sformatf("long_contig%0d", n), cyc, first + n);
        chk($sformatf("long_data%0d", n), {24'h0, bus.RdData}, {24'h0, exp_mem[n]});
        chk($sformatf("long_last%0d", n), {31'h0, bus.RdLast}, {31'h0, (n == 255)});
        n++;
      end
    end
    chk_int("long_beats", n, 256);
    @(negedge CLK); #1;
    b = 8'h00;
    chk("long_after", outs(), {H, L, L, L, L, L, b, 8'h00, L, 8'h00, L});

    chk_int("we_rd_overlap", overlap, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
    $finish;
  end

endmodule
